hbc_axil_bridge: RTL and testbench
==================================

# hbc_axil_bridge

AXI4-Lite slave that converts AXI read/write transactions into the single-outstanding `valid`/`ready` memory request interface of the HyperBus controller wrapper, `hbc_wrapper`. It sits directly upstream of `hbc_wrapper`:
- Its `o_mem_*` and `o_cfg_access` outputs connect port-for-port to the wrapper's `i_mem_*` and `i_cfg_access` inputs.
- One AXI address bit selects HyperRAM configuration-register space.
- It arbitrates fairly between reads and writes.

## Interface
- `CFG_BIT`, default 31: AXI address bit that selects config space; this bit is cleared in `o_mem_addr`.
- `i_clk`, in, 1: single clock, shared with `hbc_wrapper`.
- `i_rst`, in, 1: synchronous, active-high reset.
- `s_axil_awvalid`/`awready`, in/out, 1 each, plus `s_axil_awaddr`, in, 32: write-address channel.
- `s_axil_wvalid`/`wready`, in/out, 1 each, plus `s_axil_wdata`, in, 32, and `s_axil_wstrb`, in, 4: write-data channel.
- `s_axil_bvalid`/`bready`, out/in, 1 each, plus `s_axil_bresp`, out, 2: write-response channel.
- `s_axil_arvalid`/`arready`, in/out, 1 each, plus `s_axil_araddr`, in, 32: read-address channel.
- `s_axil_rvalid`/`rready`, out/in, 1 each, plus `s_axil_rdata`, out, 32, and `s_axil_rresp`, out, 2: read-data channel.
- `o_cfg_access`, out, 1: current request targets config space.
- `o_mem_valid`, out, 1: request valid.
- `i_mem_ready`, in, 1: one-cycle completion pulse from the controller.
- `o_mem_wstrb`, out, 4: byte strobes; 0 means read.
- `o_mem_addr`, out, 32: byte address, bits [1:0] forced to 0.
- `o_mem_wdata`, out, 32: write data.
- `i_mem_rdata`, in, 32: read data, valid in the `i_mem_ready` cycle.

## Operation
- Three holding registers, each with a full flag: AW, W and AR.
  - `awready = !aw_full`, `wready = !w_full`, `arready = !ar_full`.
  - All three readies are forced low while `i_rst` is high.
  - A register loads on its valid&&ready handshake.
  - AW and W are accepted independently, in either order.
- FSM states: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_RESP.
- IDLE:
  - A write is pending when `aw_full && w_full`; a read is pending when `ar_full`.
  - If only one kind is pending, serve it.
  - If both are pending, serve the kind opposite to the last one served. The `last_was_write` flag resets to 1, so a read wins the first tie.
  - Entering WR_ISSUE clears the AW and W full flags. Entering RD_ISSUE clears the AR full flag.
  - Write with `wstrb == 4'b0000`: skip the controller and go directly to WR_RESP with OKAY, because a zero strobe would be decoded as a read.
- WR_ISSUE / RD_ISSUE:
  - `o_mem_valid = 1`. Address, wstrb, wdata and `cfg_access` come from registers and are stable for the whole request.
  - Reads drive `wstrb = 0`.
  - `o_cfg_access = addr[CFG_BIT]`.
  - Leave the state on `i_mem_ready`. On that edge, capture `i_mem_rdata` into the `s_axil_rdata` register.
- WR_RESP: `bvalid = 1`, `bresp = 2'b00`. Return to IDLE on `bready`.
- RD_RESP: `rvalid = 1`, `rresp = 2'b00`. Return to IDLE on `rready`.
- New AW/W/AR beats may be accepted into empty holding registers during any state, giving one transaction of look-ahead.
- `i_mem_ready` outside an ISSUE state is ignored.
- Reset values:
  - state = IDLE; all full flags = 0; `bvalid` = `rvalid` = 0; `o_mem_valid` = 0.
  - `o_mem_wstrb`, `o_mem_addr`, `o_mem_wdata`, `o_cfg_access`, `s_axil_rdata`, `bresp`, `rresp` all = 0.
- Reset mid-transaction: everything above returns to reset values at the next edge and in-flight data is dropped. The system must reset `hbc_wrapper` (`i_rstn = !i_rst`) in the same cycle.

## Timing
- All outputs are registered except the three readies, which are decoded from the registered full flags.
- Minimum latency:
  - AW+W handshake at cycle 0, then `o_mem_valid` high at cycle 1.
  - `i_mem_ready` at cycle N, then `bvalid` (or `rvalid` with data) at N+1, and `o_mem_valid` low at N+1.
- `o_mem_valid` never deasserts before `i_mem_ready`, and it is never high in two consecutive requests without at least one low cycle between them.
- Zero-strobe write: handshake at cycle 0, `bvalid` at cycle 1, and `o_mem_valid` stays 0.
- Sustained throughput: one transaction per (controller latency + 2) cycles, given `bready`/`rready` held high.

## Structure
- Shared package `hbc_pkg`:
  - FSM state enum.
  - AXI response constants: `RESP_OKAY` = 2'b00, `RESP_SLVERR` = 2'b10.
  - `HBC_WSTRB_READ` = 4'b0000.
- Optional sub-module `hbc_axil_hold`: generic valid/ready holding register with a full flag, instantiated three times (AW, W, AR).
- The FSM and arbiter live in the top level.

## Test plan
- Single write, addr 0x0000_0010, data 0xDEADBEEF, strb 0xF -> `o_mem_addr` = 0x10, `o_mem_wstrb` = 0xF, `o_cfg_access` = 0; after `i_mem_ready`, `bvalid` with `bresp` = 0.
- W beat 3 cycles before AW beat, then read of 0x8000_0000 -> write issued only after AW arrives. Read then issues with `o_cfg_access` = 1, `o_mem_addr` = 0, `o_mem_wstrb` = 0, and `i_mem_rdata` 0x0000_8F1F is returned on `s_axil_rdata`.
- AR and AW+W all pending together in IDLE after reset -> read served first, then write; a repeat tie is served read first again (alternation).
- Write with wstrb = 0 -> `bvalid` one cycle after the handshake, `bresp` = 0, `o_mem_valid` never asserts.
- `i_mem_ready` delayed 20 cycles and `rready` held low 5 cycles -> `o_mem_valid` and address stable throughout, `rvalid`/`rdata` held until `rready`, no second request is issued meanwhile.
- `i_rst` pulsed while in RD_ISSUE -> next cycle `o_mem_valid` = 0, `rvalid` = 0, all readies 0 during reset and 1 after; a subsequent write completes normally.

Source files
------------

// File: rtl/hbc_pkg.sv
// Shared types and constants for the HyperBus AXI4-Lite bridge.
package hbc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ISSUE,
      ST_WR_RESP,
      ST_RD_ISSUE,
      ST_RD_RESP
   } hbc_state_e;

   localparam logic [1:0] RESP_OKAY      = 2'b00;
   localparam logic [1:0] RESP_SLVERR    = 2'b10;
   localparam logic [3:0] HBC_WSTRB_READ = 4'b0000;

   // Word-aligned controller address with the config-select bit removed.
   function automatic logic [31:0] hbc_word_addr(input logic [31:0] a,
                                                  input int unsigned cfg_bit);
      return a & ~(32'h1 << cfg_bit) & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/hbc_axil_hold.sv
// Single-entry valid/ready holding register with a full flag.
module hbc_axil_hold #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   input  logic         clr_i,
   output logic         ready_o,
   output logic         full_o,
   output logic [W-1:0] data_o
);

   logic         full_q;
   logic [W-1:0] data_q;

   assign ready_o = !full_q && !rst_i;
   assign full_o  = full_q;
   assign data_o  = data_q;

   // Load on handshake, release when the consumer takes the entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (clr_i) begin
         full_q <= 1'b0;
      end else if (valid_i && ready_o) begin
         full_q <= 1'b1;
         data_q <= data_i;
      end
   end

endmodule

// File: rtl/hbc_axil_bridge.sv
// AXI4-Lite slave to single-outstanding HyperBus memory request bridge.
module hbc_axil_bridge
   import hbc_pkg::*;
#(
   parameter int unsigned CFG_BIT = 31
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        s_axil_awvalid,
   output logic        s_axil_awready,
   input  logic [31:0] s_axil_awaddr,
   input  logic        s_axil_wvalid,
   output logic        s_axil_wready,
   input  logic [31:0] s_axil_wdata,
   input  logic [3:0]  s_axil_wstrb,
   output logic        s_axil_bvalid,
   input  logic        s_axil_bready,
   output logic [1:0]  s_axil_bresp,
   input  logic        s_axil_arvalid,
   output logic        s_axil_arready,
   input  logic [31:0] s_axil_araddr,
   output logic        s_axil_rvalid,
   input  logic        s_axil_rready,
   output logic [31:0] s_axil_rdata,
   output logic [1:0]  s_axil_rresp,
   output logic        o_cfg_access,
   output logic        o_mem_valid,
   input  logic        i_mem_ready,
   output logic [3:0]  o_mem_wstrb,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata
);

   hbc_state_e  state_q;
   logic        last_was_write_q;
   logic        mem_valid_q, cfg_q, bvalid_q, rvalid_q;
   logic [3:0]  mem_wstrb_q;
   logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;
   logic [1:0]  bresp_q, rresp_q;

   logic        aw_full, w_full, ar_full;
   logic [31:0] aw_addr, ar_addr;
   logic [35:0] w_beat;
   logic        wr_pend, rd_pend, pick_wr, pick_rd;

   assign wr_pend = aw_full && w_full;
   assign rd_pend = ar_full;
   // On a tie, serve the kind opposite to the one served last.
   assign pick_wr = (state_q == ST_IDLE) && wr_pend && (!rd_pend || !last_was_write_q);
   assign pick_rd = (state_q == ST_IDLE) && rd_pend && !pick_wr;

   hbc_axil_hold #(.W(32)) u_aw (
      .clk_i(i_clk), .rst_i(i_rst), .valid_i(s_axil_awvalid), .data_i(s_axil_awaddr),
      .clr_i(pick_wr), .ready_o(s_axil_awready), .full_o(aw_full), .data_o(aw_addr)
   );

   hbc_axil_hold #(.W(36)) u_w (
      .clk_i(i_clk), .rst_i(i_rst), .valid_i(s_axil_wvalid), .data_i({s_axil_wstrb, s_axil_wdata}),
      .clr_i(pick_wr), .ready_o(s_axil_wready), .full_o(w_full), .data_o(w_beat)
   );

   hbc_axil_hold #(.W(32)) u_ar (
      .clk_i(i_clk), .rst_i(i_rst), .valid_i(s_axil_arvalid), .data_i(s_axil_araddr),
      .clr_i(pick_rd), .ready_o(s_axil_arready), .full_o(ar_full), .data_o(ar_addr)
   );

   // Transaction FSM with registered request and response outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q          <= ST_IDLE;
         last_was_write_q <= 1'b1;
         mem_valid_q      <= 1'b0;
         cfg_q            <= 1'b0;
         bvalid_q         <= 1'b0;
         rvalid_q         <= 1'b0;
         mem_wstrb_q      <= '0;
         mem_addr_q       <= '0;
         mem_wdata_q      <= '0;
         rdata_q          <= '0;
         bresp_q          <= RESP_OKAY;
         rresp_q          <= RESP_OKAY;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_wr) begin
                  last_was_write_q <= 1'b1;
                  if (w_beat[35:32] == HBC_WSTRB_READ) begin
                     // A zero strobe would look like a read downstream.
                     bvalid_q <= 1'b1;
                     bresp_q  <= RESP_OKAY;
                     state_q  <= ST_WR_RESP;
                  end else begin
                     mem_valid_q <= 1'b1;
                     mem_addr_q  <= hbc_word_addr(aw_addr, CFG_BIT);
                     cfg_q       <= aw_addr[CFG_BIT];
                     mem_wstrb_q <= w_beat[35:32];
                     mem_wdata_q <= w_beat[31:0];
                     state_q     <= ST_WR_ISSUE;
                  end
               end else if (pick_rd) begin
                  last_was_write_q <= 1'b0;
                  mem_valid_q      <= 1'b1;
                  mem_addr_q       <= hbc_word_addr(ar_addr, CFG_BIT);
                  cfg_q            <= ar_addr[CFG_BIT];
                  mem_wstrb_q      <= HBC_WSTRB_READ;
                  mem_wdata_q      <= '0;
                  state_q          <= ST_RD_ISSUE;
               end
            end
            ST_WR_ISSUE: begin
               if (i_mem_ready) begin
                  mem_valid_q <= 1'b0;
                  bvalid_q    <= 1'b1;
                  bresp_q     <= RESP_OKAY;
                  state_q     <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (s_axil_bready) begin
                  bvalid_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            ST_RD_ISSUE: begin
               if (i_mem_ready) begin
                  mem_valid_q <= 1'b0;
                  rvalid_q    <= 1'b1;
                  rresp_q     <= RESP_OKAY;
                  rdata_q     <= i_mem_rdata;
                  state_q     <= ST_RD_RESP;
               end
            end
            ST_RD_RESP: begin
               if (s_axil_rready) begin
                  rvalid_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_mem_valid   = mem_valid_q;
   assign o_mem_addr    = mem_addr_q;
   assign o_mem_wstrb   = mem_wstrb_q;
   assign o_mem_wdata   = mem_wdata_q;
   assign o_cfg_access  = cfg_q;
   assign s_axil_bvalid = bvalid_q;
   assign s_axil_bresp  = bresp_q;
   assign s_axil_rvalid = rvalid_q;
   assign s_axil_rresp  = rresp_q;
   assign s_axil_rdata  = rdata_q;

endmodule

// File: tb/tb_hbc_axil_bridge.sv
// Bench for hbc_axil_bridge: transaction-level model checked every cycle.
module tb_hbc_axil_bridge;

   localparam int unsigned CFG = 31;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        s_axil_awvalid = 1'b0, s_axil_awready;
   logic [31:0] s_axil_awaddr = '0;
   logic        s_axil_wvalid = 1'b0, s_axil_wready;
   logic [31:0] s_axil_wdata = '0;
   logic [3:0]  s_axil_wstrb = '0;
   logic        s_axil_bvalid, s_axil_bready = 1'b1;
   logic [1:0]  s_axil_bresp;
   logic        s_axil_arvalid = 1'b0, s_axil_arready;
   logic [31:0] s_axil_araddr = '0;
   logic        s_axil_rvalid, s_axil_rready = 1'b1;
   logic [31:0] s_axil_rdata;
   logic [1:0]  s_axil_rresp;
   logic        o_cfg_access, o_mem_valid;
   logic        i_mem_ready = 1'b0;
   logic [3:0]  o_mem_wstrb;
   logic [31:0] o_mem_addr, o_mem_wdata;
   logic [31:0] i_mem_rdata = '0;

   always #5 i_clk = ~i_clk;

   hbc_axil_bridge #(.CFG_BIT(CFG)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready), .s_axil_awaddr(s_axil_awaddr),
      .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_wdata(s_axil_wdata),
      .s_axil_wstrb(s_axil_wstrb),
      .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_bresp(s_axil_bresp),
      .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready), .s_axil_araddr(s_axil_araddr),
      .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready), .s_axil_rdata(s_axil_rdata),
      .s_axil_rresp(s_axil_rresp),
      .o_cfg_access(o_cfg_access), .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
      .o_mem_wstrb(o_mem_wstrb), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .i_mem_rdata(i_mem_rdata)
   );

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { logic [31:0] data; logic [3:0] strb; } wbeat_t;
   typedef enum { M_NONE, M_WR, M_RD } kind_e;

   logic [31:0] m_awq[$], m_arq[$];
   wbeat_t      m_wq[$];
   kind_e       m_kind = M_NONE;
   bit          m_waiting = 1'b0;
   bit          m_lastw = 1'b1;
   logic        m_valid, m_cfg, m_bvalid, m_rvalid;
   logic [3:0]  m_wstrb;
   logic [31:0] m_addr, m_wdata, m_rdata;

   initial forever begin : model
      bit aw_ok, w_ok, ar_ok, do_wr, do_rd;
      logic [31:0] a;
      wbeat_t wb;
      @(posedge i_clk);
      if (i_rst) begin
         m_awq.delete(); m_wq.delete(); m_arq.delete();
         m_kind = M_NONE; m_waiting = 1'b0; m_lastw = 1'b1;
         m_valid = 0; m_cfg = 0; m_bvalid = 0; m_rvalid = 0;
         m_wstrb = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
      end else begin
         aw_ok = s_axil_awvalid && (m_awq.size() == 0);
         w_ok  = s_axil_wvalid  && (m_wq.size()  == 0);
         ar_ok = s_axil_arvalid && (m_arq.size() == 0);
         if (m_kind == M_NONE) begin
            do_wr = (m_awq.size() > 0) && (m_wq.size() > 0);
            do_rd = (m_arq.size() > 0);
            if (do_wr && do_rd) begin
               do_wr = !m_lastw;
               do_rd = m_lastw;
            end
            if (do_wr) begin
               a = m_awq.pop_front();
               wb = m_wq.pop_front();
               m_lastw = 1'b1;
               m_kind = M_WR;
               if (wb.strb == 4'd0) begin
                  m_bvalid = 1'b1;
               end else begin
                  m_waiting = 1'b1;
                  m_valid = 1'b1;
                  m_addr = a & ~(32'h1 << CFG) & 32'hFFFF_FFFC;
                  m_cfg = a[CFG];
                  m_wstrb = wb.strb;
                  m_wdata = wb.data;
               end
            end else if (do_rd) begin
               a = m_arq.pop_front();
               m_lastw = 1'b0;
               m_kind = M_RD;
               m_waiting = 1'b1;
               m_valid = 1'b1;
               m_addr = a & ~(32'h1 << CFG) & 32'hFFFF_FFFC;
               m_cfg = a[CFG];
               m_wstrb = 4'd0;
               m_wdata = 32'd0;
            end
         end else if (m_waiting) begin
            if (i_mem_ready) begin
               m_waiting = 1'b0;
               m_valid = 1'b0;
               if (m_kind == M_RD) begin
                  m_rdata = i_mem_rdata;
                  m_rvalid = 1'b1;
               end else begin
                  m_bvalid = 1'b1;
               end
            end
         end else begin
            if (m_kind == M_WR && s_axil_bready) begin
               m_bvalid = 1'b0;
               m_kind = M_NONE;
            end else if (m_kind == M_RD && s_axil_rready) begin
               m_rvalid = 1'b0;
               m_kind = M_NONE;
            end
         end
         if (aw_ok) m_awq.push_back(s_axil_awaddr);
         if (w_ok)  m_wq.push_back('{data: s_axil_wdata, strb: s_axil_wstrb});
         if (ar_ok) m_arq.push_back(s_axil_araddr);
      end
   end

   // ---------------- every-cycle comparison ----------------
   initial forever begin : compare
      @(negedge i_clk);
      if (chk_en) begin
         chk("awready", 32'(s_axil_awready), 32'(!i_rst && m_awq.size() == 0));
         chk("wready",  32'(s_axil_wready),  32'(!i_rst && m_wq.size()  == 0));
         chk("arready", 32'(s_axil_arready), 32'(!i_rst && m_arq.size() == 0));
         chk("mem_valid", 32'(o_mem_valid), 32'(m_valid));
         chk("bvalid", 32'(s_axil_bvalid), 32'(m_bvalid));
         chk("rvalid", 32'(s_axil_rvalid), 32'(m_rvalid));
         chk("bresp", 32'(s_axil_bresp), 32'd0);
         chk("rresp", 32'(s_axil_rresp), 32'd0);
         chk("mem_addr", o_mem_addr, m_addr);
         chk("mem_wstrb", 32'(o_mem_wstrb), 32'(m_wstrb));
         chk("mem_wdata", o_mem_wdata, m_wdata);
         chk("cfg_access", 32'(o_cfg_access), 32'(m_cfg));
         chk("rdata", s_axil_rdata, m_rdata);
      end
   end

   // ---------------- request / response log ----------------
   typedef struct { logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; logic cfg; } req_t;
   req_t        reqs[$];
   logic [31:0] rq[$];
   int          n_b = 0;
   logic        prev_valid = 1'b0;

   initial forever begin : monitor
      @(negedge i_clk);
      if (o_mem_valid === 1'b1 && !prev_valid)
         reqs.push_back('{addr: o_mem_addr, strb: o_mem_wstrb, wdata: o_mem_wdata, cfg: o_cfg_access});
      prev_valid = (o_mem_valid === 1'b1);
      if (s_axil_bvalid === 1'b1 && s_axil_bready) n_b++;
      if (s_axil_rvalid === 1'b1 && s_axil_rready) rq.push_back(s_axil_rdata);
   end

   // ---------------- controller emulation ----------------
   int          ctl_lat = 1;
   logic [31:0] ctl_rdata = '0;

   initial begin : ctl
      int cnt;
      cnt = 0;
      forever begin
         @(posedge i_clk);
         #1;
         if (o_mem_valid === 1'b1 && !i_mem_ready) begin
            cnt++;
            if (cnt >= ctl_lat) begin
               i_mem_ready = 1'b1;
               i_mem_rdata = ctl_rdata;
               cnt = 0;
            end
         end else begin
            i_mem_ready = 1'b0;
            cnt = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic send_aw(input logic [31:0] a);
      bit ok;
      ok = 1'b0;
      s_axil_awaddr = a;
      s_axil_awvalid = 1'b1;
      for (int i = 0; i < 80; i++) begin
         ok = s_axil_awready;
         tick(1);
         if (ok) break;
      end
      s_axil_awvalid = 1'b0;
      chk("aw_handshake", 32'(ok), 32'd1);
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      bit ok;
      ok = 1'b0;
      s_axil_wdata = d;
      s_axil_wstrb = s;
      s_axil_wvalid = 1'b1;
      for (int i = 0; i < 80; i++) begin
         ok = s_axil_wready;
         tick(1);
         if (ok) break;
      end
      s_axil_wvalid = 1'b0;
      chk("w_handshake", 32'(ok), 32'd1);
   endtask

   task automatic send_ar(input logic [31:0] a);
      bit ok;
      ok = 1'b0;
      s_axil_araddr = a;
      s_axil_arvalid = 1'b1;
      for (int i = 0; i < 80; i++) begin
         ok = s_axil_arready;
         tick(1);
         if (ok) break;
      end
      s_axil_arvalid = 1'b0;
      chk("ar_handshake", 32'(ok), 32'd1);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin : main
      int r0, b0, q0;
      bit seen;
      tick(2);
      chk_en = 1'b1;
      chk("rst_awready", 32'(s_axil_awready), 32'd0);
      chk("rst_mem_valid", 32'(o_mem_valid), 32'd0);
      chk("rst_mem_addr", o_mem_addr, 32'd0);
      tick(1);
      i_rst = 1'b0;
      tick(1);
      chk("post_rst_ready", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'h7);

      // Tie straight after reset: read first, then write; repeat tie -> read first again.
      r0 = reqs.size();
      fork
         send_aw(32'h0000_0100);
         send_w(32'h0A0A_0A0A, 4'hF);
         send_ar(32'h0000_0200);
      join
      tick(15);
      fork
         send_aw(32'h0000_0104);
         send_w(32'h0B0B_0B0B, 4'h3);
         send_ar(32'h0000_0300);
      join
      tick(15);
      chk("tie_nreq", 32'(reqs.size() - r0), 32'd4);
      if (reqs.size() - r0 == 4) begin
         chk("tie1_first_rd", 32'(reqs[r0].strb), 32'h0);
         chk("tie1_first_addr", reqs[r0].addr, 32'h200);
         chk("tie1_second_wr", 32'(reqs[r0+1].strb), 32'hF);
         chk("tie1_second_addr", reqs[r0+1].addr, 32'h100);
         chk("tie2_first_rd", reqs[r0+2].addr, 32'h300);
         chk("tie2_second_strb", 32'(reqs[r0+3].strb), 32'h3);
      end

      // Single write.
      r0 = reqs.size(); b0 = n_b;
      fork
         send_aw(32'h0000_0010);
         send_w(32'hDEAD_BEEF, 4'hF);
      join
      tick(10);
      chk("w1_nreq", 32'(reqs.size() - r0), 32'd1);
      chk("w1_nresp", 32'(n_b - b0), 32'd1);
      if (reqs.size() > r0) begin
         chk("w1_addr", reqs[r0].addr, 32'h10);
         chk("w1_strb", 32'(reqs[r0].strb), 32'hF);
         chk("w1_data", reqs[r0].wdata, 32'hDEAD_BEEF);
         chk("w1_cfg", 32'(reqs[r0].cfg), 32'd0);
      end

      // W beat ahead of AW, then a config-space read.
      r0 = reqs.size(); q0 = rq.size();
      ctl_rdata = 32'h0000_8F1F;
      send_w(32'h1122_3344, 4'hF);
      tick(3);
      chk("w_early_noreq", 32'(reqs.size() - r0), 32'd0);
      send_aw(32'h0000_0020);
      send_ar(32'h8000_0000);
      tick(15);
      chk("cfg_nreq", 32'(reqs.size() - r0), 32'd2);
      if (reqs.size() - r0 == 2) begin
         chk("late_aw_addr", reqs[r0].addr, 32'h20);
         chk("cfg_rd_cfg", 32'(reqs[r0+1].cfg), 32'd1);
         chk("cfg_rd_addr", reqs[r0+1].addr, 32'h0);
         chk("cfg_rd_strb", 32'(reqs[r0+1].strb), 32'h0);
      end
      if (rq.size() > q0) chk("cfg_rd_data", rq[q0], 32'h0000_8F1F);
      chk("cfg_nrdata", 32'(rq.size() - q0), 32'd1);

      // Zero-strobe write bypasses the controller.
      r0 = reqs.size();
      fork
         send_aw(32'h0000_0040);
         send_w(32'h5555_AAAA, 4'h0);
      join
      chk("zs_bvalid_c0", 32'(s_axil_bvalid), 32'd0);
      tick(1);
      chk("zs_bvalid_c1", 32'(s_axil_bvalid), 32'd1);
      chk("zs_bresp", 32'(s_axil_bresp), 32'd0);
      tick(5);
      chk("zs_noreq", 32'(reqs.size() - r0), 32'd0);

      // Slow controller and stalled rready, with a write queued behind.
      r0 = reqs.size(); q0 = rq.size();
      s_axil_rready = 1'b0;
      ctl_lat = 20;
      ctl_rdata = 32'h1234_5678;
      send_ar(32'h0000_0080);
      fork
         send_aw(32'h0000_0090);
         send_w(32'hCAFE_F00D, 4'hC);
      join
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (s_axil_rvalid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick(1);
      end
      chk("slow_rvalid_seen", 32'(seen), 32'd1);
      ctl_lat = 1;
      for (int i = 0; i < 5; i++) begin
         chk("slow_rvalid_hold", 32'(s_axil_rvalid), 32'd1);
         chk("slow_rdata_hold", s_axil_rdata, 32'h1234_5678);
         chk("slow_no_2nd_req", 32'(reqs.size() - r0), 32'd1);
         tick(1);
      end
      s_axil_rready = 1'b1;
      tick(10);
      chk("slow_nreq", 32'(reqs.size() - r0), 32'd2);
      if (reqs.size() - r0 == 2) chk("slow_wr_addr", reqs[r0+1].addr, 32'h90);

      // Reset during a read request.
      ctl_lat = 1000;
      send_ar(32'h8000_0004);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (o_mem_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick(1);
      end
      chk("rst_rd_issued", 32'(seen), 32'd1);
      i_rst = 1'b1;
      #1;
      chk("rst_readies_low", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'h0);
      @(posedge i_clk);
      #1;
      chk("rst_valid_drop", 32'(o_mem_valid), 32'd0);
      chk("rst_rvalid_drop", 32'(s_axil_rvalid), 32'd0);
      i_rst = 1'b0;
      ctl_lat = 1;
      #1;
      chk("rst_readies_high", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'h7);
      tick(1);
      r0 = reqs.size(); b0 = n_b;
      fork
         send_aw(32'h0000_0050);
         send_w(32'h0F0F_0F0F, 4'hF);
      join
      tick(10);
      chk("post_rst_nresp", 32'(n_b - b0), 32'd1);
      if (reqs.size() > r0) chk("post_rst_addr", reqs[r0].addr, 32'h50);

      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
